// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcodes, ALU handshake states and default datapath width.
package cpu_pkg;
    localparam int WIDTH_DEF = 16;
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} alu_state_t;
endpackage

// File: rtl/alu_digit_adder.sv
// alu_digit_adder: combinational DIGIT_W-bit adder with carry in/out, reused each serial step.
module alu_digit_adder #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
endmodule

// File: rtl/serial_alu.sv
// serial_alu: digit-serial add/sub (LSB first) behind an alu_start/alu_done four-phase handshake.
// Define SERIAL_ALU_FLAGS_EN to build the Z/C/V flag registers; otherwise the flags read 0.
module serial_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_start,
    input  logic             alu_op,
    input  logic             immediate,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] sgnext_imm,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_done,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int STEPS = WIDTH / DIGIT_W;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    alu_state_t state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh, sum_sh, sum_next, b_sel, b_in;
    logic [CW-1:0]      cnt;
    logic               carry, cout, accept, step, step_last;
    logic [DIGIT_W-1:0] dsum;

    assign b_sel     = immediate ? sgnext_imm : operand_b;
    assign b_in      = (alu_op == ALU_OP_ADD) ? b_sel : ~b_sel;
    assign accept    = (state == IDLE) && alu_start;
    assign step      = (state == CALC) && alu_start;
    assign step_last = step && (cnt == CW'(STEPS - 1));
    // New digit enters at the top so the LSB digit ends up at bit 0 after STEPS shifts
    assign sum_next  = (sum_sh >> DIGIT_W) | (WIDTH'(dsum) << (WIDTH - DIGIT_W));

    alu_digit_adder #(.DIGIT_W(DIGIT_W)) u_add (
        .a    (a_sh[DIGIT_W-1:0]),
        .b    (b_sh[DIGIT_W-1:0]),
        .cin  (carry),
        .sum  (dsum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = alu_start ? CALC : IDLE;
            CALC:    state_nxt = !alu_start ? IDLE : step_last ? DONE : CALC;
            DONE:    state_nxt = alu_start ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            alu_result <= '0;
            alu_done   <= 1'b0;
        end else begin
            if (accept) begin
                a_sh  <= operand_a;
                b_sh  <= b_in;
                carry <= (alu_op == ALU_OP_SUB);
                cnt   <= '0;
            end
            if (step) begin
                a_sh   <= a_sh >> DIGIT_W;
                b_sh   <= b_sh >> DIGIT_W;
                sum_sh <= sum_next;
                carry  <= cout;
                cnt    <= cnt + CW'(1);
            end
            if (step_last) begin
                alu_result <= sum_next;
                alu_done   <= 1'b1;
            end
            if (state == DONE && !alu_start) alu_done <= 1'b0;
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    logic a_msb, b_msb;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= operand_a[WIDTH-1];
                b_msb <= b_in[WIDTH-1];
            end
            if (step_last) begin
                flag_z <= (sum_next == '0);
                flag_c <= cout;
                flag_v <= (a_msb == b_msb) && (sum_next[WIDTH-1] != a_msb);
            end
        end
    end
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
    assign flag_v = 1'b0;
`endif
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed vectors for serial_alu covering add/sub/imm, handshake hold, abort and reset.
module tb_serial_alu;
    import cpu_pkg::*;
    localparam int W = 16;
`ifdef SERIAL_ALU_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic         clk = 1'b0, reset = 1'b1, alu_start = 1'b0, alu_op = 1'b0, immediate = 1'b0;
    logic [W-1:0] operand_a = '0, operand_b = '0, sgnext_imm = '0, alu_result;
    logic         alu_done, flag_z, flag_c, flag_v;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    serial_alu #(.WIDTH(W), .DIGIT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .immediate  (immediate),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .sgnext_imm (sgnext_imm),
        .alu_result (alu_result),
        .alu_done   (alu_done),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_v     (flag_v)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic z, input logic c, input logic v);
        check({tag, "_z"}, W'(flag_z), W'(FL & z));
        check({tag, "_c"}, W'(flag_c), W'(FL & c));
        check({tag, "_v"}, W'(flag_v), W'(FL & v));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, b, imm_v, input logic op, imm,
                          input int extra, input logic [W-1:0] exp, input logic z, c, v);
        int lat = 0;
        @(negedge clk);
        operand_a = a; operand_b = b; sgnext_imm = imm_v; alu_op = op; immediate = imm; alu_start = 1'b1;
        @(posedge clk);
        #1 operand_a = ~a; operand_b = ~b; sgnext_imm = ~imm_v;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (alu_done) lat = k;
        end
        check({tag, "_lat"}, W'(lat), W'(4));
        check({tag, "_res"}, alu_result, exp);
        check_flags(tag, z, c, v);
        for (int k = 0; k < extra; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_done"}, W'(alu_done), W'(1));
            check({tag, "_hold_res"}, alu_result, exp);
        end
        @(negedge clk) alu_start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_drop_done"}, W'(alu_done), W'(0));
        check({tag, "_keep_res"}, alu_result, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", alu_result, 16'h0000);
        check("rst_done", W'(alu_done), W'(0));
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b0;

        run_op("add", 16'h1234, 16'h0FCD, 16'h0000, ALU_OP_ADD, 1'b0, 0, 16'h2201, 1'b0, 1'b0, 1'b0);
        run_op("sub", 16'h0005, 16'h0007, 16'h0000, ALU_OP_SUB, 1'b0, 0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("imm", 16'h0010, 16'h1111, 16'hFFF0, ALU_OP_ADD, 1'b1, 0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("ovf", 16'h7FFF, 16'h0001, 16'h0000, ALU_OP_ADD, 1'b0, 3, 16'h8000, 1'b0, 1'b0, 1'b1);
        run_op("restart", 16'h0003, 16'h0002, 16'h0000, ALU_OP_ADD, 1'b0, 0, 16'h0005, 1'b0, 1'b0, 1'b0);

        // abort after two CALC cycles: previous result and flags must survive
        @(negedge clk);
        operand_a = 16'h1111; operand_b = 16'h1111; alu_op = ALU_OP_ADD; immediate = 1'b0; alu_start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) alu_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("abort_done", W'(alu_done), W'(0));
        end
        check("abort_res", alu_result, 16'h0005);
        check_flags("abort", 1'b0, 1'b0, 1'b0);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        operand_a = 16'hFFFF; operand_b = 16'hFFFF; alu_start = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_res", alu_result, 16'h0000);
        check("arst_done", W'(alu_done), W'(0));
        check_flags("arst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0; alu_start = 1'b0;

        run_op("post", 16'hFFFF, 16'h0001, 16'h0000, ALU_OP_SUB, 1'b0, 0, 16'hFFFE, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Multi-cycle ALU that answers the control unit's alu_start/alu_done handshake.
- Computes A+B or A-B, where B is either register operand_b or sgnext_imm, selected by `immediate`.
- Processes DIGIT_W bits per cycle (digit-serial, LSB first) to keep adder area small.
- Sits between the register file read ports and the control unit's EXEC/MEM/WB path.

Parameters:
- WIDTH, 16, datapath width in bits.
- DIGIT_W, 4, bits processed per CALC cycle. Must divide WIDTH; legal range 1..WIDTH.
- STEPS is derived (localparam): WIDTH/DIGIT_W, default 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_start  in  1  level request. Held high by the control unit until it has consumed the result.
- alu_op  in  1  0 = add, 1 = sub.
- immediate  in  1  1 = use sgnext_imm as B; 0 = use operand_b.
- operand_a  in  WIDTH  register rs1 data.
- operand_b  in  WIDTH  register rs2 data.
- sgnext_imm  in  WIDTH  sign-extended immediate.
- alu_result  out  WIDTH  registered result.
- alu_done  out  1  registered completion flag.
- flag_z  out  1  result zero.
- flag_c  out  1  carry out of MSB; for sub, 1 = no borrow.
- flag_v  out  1  signed overflow.

Behaviour:
- Reset: all outputs are 0 and state = IDLE, asynchronously.
- States: IDLE, CALC, DONE.
- IDLE, on an edge with alu_start=1:
  - Latch A = operand_a.
  - Latch B = (immediate ? sgnext_imm : operand_b), inverted when alu_op=1.
  - Set carry = alu_op and digit counter = 0.
  - Go to CALC.
  - Inputs are sampled only at this edge; later changes are ignored.
- CALC, each edge:
  - Add the low DIGIT_W bits of A and B with the carry.
  - Shift the sum digit into the top of the result shift register; shift A and B right by DIGIT_W.
  - Update carry; counter++.
  - When counter == STEPS-1, load alu_result (and flags), set alu_done=1 and go to DONE.
- Latency: acceptance at edge E gives alu_done high and alu_result valid after edge E+STEPS (default 4 cycles).
- DONE:
  - alu_done stays high and alu_result is held while alu_start=1.
  - When alu_start=0 at an edge: alu_done←0, go to IDLE. alu_result keeps its value.
  - A new request is accepted no earlier than the edge after returning to IDLE (four-phase handshake).
- Abort: alu_start=0 at any CALC edge → go to IDLE. alu_done is never asserted, and alu_result and flags are unchanged.
- Arithmetic: modulo 2^WIDTH. Subtraction is A + ~B + 1. No saturation.
- alu_op and immediate values outside the decoded set do not exist (1-bit each). Behaviour is exactly as above for all input combinations.
- Reset mid-CALC or mid-DONE: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro: SERIAL_ALU_FLAGS_EN.
- Defined:
  - flag_z, flag_c and flag_v are registered together with alu_result on entry to DONE.
  - flag_z = (result==0).
  - flag_c = final carry.
  - flag_v = (A[MSB]==B'[MSB]) && (result[MSB]!=A[MSB]), using the original MSBs.
  - Flags hold like alu_result.
- Undefined: flag outputs are tied to 0 and no flag or MSB-capture logic is synthesised. Ports remain present.

Decomposition:
- Package cpu_pkg:
  - ALU_OP_ADD=1'b0, ALU_OP_SUB=1'b1.
  - alu_state_t enum {IDLE, CALC, DONE}.
  - Default WIDTH constant.
- Sub-module alu_digit_adder: combinational DIGIT_W-bit adder with carry in/out. It is instantiated once and reused every CALC cycle.

Test Plan:
- Add: A=0x1234, B=0x0FCD, op=0, imm=0, start held → alu_done rises 4 cycles after acceptance, result 0x2201, Z=0 C=0 V=0.
- Sub: A=0x0005, B=0x0007, op=1 → result 0xFFFE, C=0 (borrow), V=0.
- Immediate add: A=0x0010, sgnext_imm=0xFFF0, operand_b=0x1111, imm=1 → result 0x0000, Z=1, C=1.
- Overflow and handshake: A=0x7FFF, B=0x0001, add → result 0x8000, V=1.
  - Keep start high 3 extra cycles → done stays high and result is stable.
  - Drop start → done low next edge; restart next cycle is accepted.
- Abort and reset:
  - Drop start after 2 CALC cycles → done never rises and previous result is retained.
  - Assert reset during CALC → all outputs 0 immediately.
  - The next request completes normally.
